// File: rtl/cfu_l2_initiator.sv
// cfu_l2_initiator: CFU-L2 initiator with request holding register, outstanding limit, response skid buffer and optional watchdog (CFU_L2_INITIATOR_TIMEOUT_EN)
module cfu_l2_initiator #(
    parameter int CFU_FUNC_ID_W   = 10,
    parameter int CFU_DATA_W      = 32,
    parameter int CFU_STATE_ID_W  = 1,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      clk_en,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CFU_STATE_ID_W-1:0] cmd_state,
    input  logic [CFU_FUNC_ID_W-1:0]  cmd_func,
    input  logic [CFU_DATA_W-1:0]     cmd_data0,
    input  logic [CFU_DATA_W-1:0]     cmd_data1,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic                      req_cfu,
    output logic [CFU_STATE_ID_W-1:0] req_state,
    output logic [CFU_FUNC_ID_W-1:0]  req_func,
    output logic                      req_insn,
    output logic [CFU_DATA_W-1:0]     req_data0,
    output logic [CFU_DATA_W-1:0]     req_data1,
    input  logic                      resp_valid,
    output logic                      resp_ready,
    input  logic [2:0]                resp_status,
    input  logic [CFU_DATA_W-1:0]     resp_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [2:0]                rsp_status,
    output logic [CFU_DATA_W-1:0]     rsp_data,
    output logic [15:0]               err_count,
    output logic [3:0]                outstanding,
    output logic                      timeout
);
    typedef enum logic {EMPTY, FULL} hold_t;
    hold_t                 hold;
    logic                  req_hs, cmd_hs, resp_hs, sb_push, sb_pop, sb_wr, sb_rd;
    logic [1:0]            sb_count;
    logic [2:0]            sb_status [2];
    logic [CFU_DATA_W-1:0] sb_data [2];

    assign clk_en     = 1'b1;
    assign req_cfu    = 1'b0;
    assign req_insn   = 1'b0;
    assign req_valid  = hold == FULL;
    assign req_hs     = req_valid & req_ready;
    assign cmd_ready  = !rst && (hold == EMPTY || req_hs) &&
                        (({1'b0, outstanding} + 5'(req_valid)) < 5'(MAX_OUTSTANDING));
    assign cmd_hs     = cmd_valid & cmd_ready;
    assign resp_ready = !rst && sb_count != 2'd2 && outstanding != 4'd0;
    assign resp_hs    = resp_valid & resp_ready;
    assign sb_pop     = rsp_ready && sb_count != 2'd0;
    assign sb_push    = resp_hs && !(sb_count == 2'd0 && rsp_ready);
    assign rsp_valid  = sb_count != 2'd0 || resp_hs;
    assign rsp_status = sb_count != 2'd0 ? sb_status[sb_rd] : resp_hs ? resp_status : 3'd0;
    assign rsp_data   = sb_count != 2'd0 ? sb_data[sb_rd] : resp_hs ? resp_data : '0;

    // Holding register: capture a command, hold it stable until the request handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= EMPTY;
            req_state <= '0;
            req_func  <= '0;
            req_data0 <= '0;
            req_data1 <= '0;
        end else if (cmd_hs) begin
            hold      <= FULL;
            req_state <= cmd_state;
            req_func  <= cmd_func;
            req_data0 <= cmd_data0;
            req_data1 <= cmd_data1;
        end else if (req_hs) begin
            hold <= EMPTY;
        end
    end

    // In-flight count: up on request handshake, down on response handshake
    always_ff @(posedge clk) begin
        if (rst)
            outstanding <= 4'd0;
        else if (req_hs && !resp_hs)
            outstanding <= outstanding + 4'd1;
        else if (!req_hs && resp_hs)
            outstanding <= outstanding - 4'd1;
    end

    // Skid buffer pointers and occupancy; storage is only written on push
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_count <= 2'd0;
            sb_wr    <= 1'b0;
            sb_rd    <= 1'b0;
        end else begin
            sb_count <= sb_count + 2'(sb_push) - 2'(sb_pop);
            if (sb_push)
                sb_wr <= ~sb_wr;
            if (sb_pop)
                sb_rd <= ~sb_rd;
        end
    end

    // Skid buffer storage
    always_ff @(posedge clk) begin
        if (sb_push) begin
            sb_status[sb_wr] <= resp_status;
            sb_data[sb_wr]   <= resp_data;
        end
    end

    // Saturating count of responses carrying a nonzero status
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= 16'd0;
        else if (resp_hs && resp_status != 3'd0 && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end

`ifdef CFU_L2_INITIATOR_TIMEOUT_EN
    logic [15:0] wd_cnt, wd_next;

    assign wd_next = (resp_hs || outstanding == 4'd0) ? 16'd0 :
                     (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'd1;

    // Watchdog: counts cycles without response progress, sticky flag on expiry
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= 16'd0;
            timeout <= 1'b0;
        end else begin
            wd_cnt <= wd_next;
            if (wd_next >= 16'(TIMEOUT_CYCLES))
                timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_cfu_l2_initiator.sv
// tb_cfu_l2_initiator: directed scenarios plus randomized traffic against a queue-based reference model
module tb_cfu_l2_initiator;
    localparam int MAXO = 4;

    typedef struct packed {logic [0:0] st; logic [9:0] fn; logic [31:0] d0; logic [31:0] d1;} cmd_t;
    typedef struct packed {logic [2:0] s; logic [31:0] d;} rsp_t;

    logic        clk, rst, clk_en;
    logic        cmd_valid, cmd_ready;
    logic [0:0]  cmd_state;
    logic [9:0]  cmd_func;
    logic [31:0] cmd_data0, cmd_data1;
    logic        req_valid, req_ready, req_cfu, req_insn;
    logic [0:0]  req_state;
    logic [9:0]  req_func;
    logic [31:0] req_data0, req_data1;
    logic        resp_valid, resp_ready;
    logic [2:0]  resp_status;
    logic [31:0] resp_data;
    logic        rsp_valid, rsp_ready;
    logic [2:0]  rsp_status;
    logic [31:0] rsp_data;
    logic [15:0] err_count;
    logic [3:0]  outstanding;
    logic        timeout;
    int          checks = 0;
    int          errors = 0;

    cfu_l2_initiator #(
        .CFU_FUNC_ID_W(10), .CFU_DATA_W(32), .CFU_STATE_ID_W(1),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_state(cmd_state), .cmd_func(cmd_func),
        .cmd_data0(cmd_data0), .cmd_data1(cmd_data1),
        .req_valid(req_valid), .req_ready(req_ready), .req_cfu(req_cfu), .req_state(req_state),
        .req_func(req_func), .req_insn(req_insn), .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status), .resp_data(resp_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data),
        .err_count(err_count), .outstanding(outstanding), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not complete in time");
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1; cmd_valid = 0; resp_valid = 0; req_ready = 0; rsp_ready = 0;
        tick;
        tick;
        rst = 0;
    endtask

    task automatic issue(input int n);
        int acc = 0;
        req_ready = 1;
        for (int c = 0; c < 60 && acc < n; c++) begin
            cmd_valid = 1; cmd_state = 1'($urandom); cmd_func = 10'($urandom);
            cmd_data0 = $urandom; cmd_data1 = $urandom;
            #1;
            if (cmd_ready) acc++;
            tick;
        end
        cmd_valid = 0;
        tick;
        tick;
    endtask

    task automatic respond(input logic [2:0] st, input logic [31:0] d);
        resp_valid = 1; resp_status = st; resp_data = d;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (resp_ready) begin
                tick;
                resp_valid = 0;
                return;
            end
            tick;
        end
        resp_valid = 0;
    endtask

    task automatic test_reset;
        rst = 1; cmd_valid = 1; resp_valid = 1; req_ready = 1; rsp_ready = 1;
        cmd_state = 0; cmd_func = 10'd9; cmd_data0 = 32'd1; cmd_data1 = 32'd2;
        resp_status = 3'd2; resp_data = 32'hDEAD;
        tick;
        tick;
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 0", cmd_ready); end
        checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL reset_resp_ready: got %0b want 0", resp_ready); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b want 0", req_valid); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        checks++; if ({rsp_status, rsp_data} !== 35'd0) begin errors++; $display("FAIL reset_rsp_fields: got %0h/%0h want 0/0", rsp_status, rsp_data); end
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
        checks++; if ({clk_en, req_cfu, req_insn} !== 3'b100) begin errors++; $display("FAIL reset_ties: got %b want 100", {clk_en, req_cfu, req_insn}); end
        rst = 0; cmd_valid = 0; resp_valid = 0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_cmd_ready: got %0b want 1", cmd_ready); end
        tick;
    endtask

    task automatic test_single;
        do_reset;
        cmd_valid = 1; cmd_state = 0; cmd_func = 10'd3; cmd_data0 = 32'd5; cmd_data1 = 32'd7;
        req_ready = 1; rsp_ready = 1;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL single_cmd_ready: got %0b want 1", cmd_ready); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL single_req_early: got %0b want 0", req_valid); end
        tick;
        cmd_valid = 0;
        #1;
        checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL single_req_valid: got %0b want 1", req_valid); end
        checks++; if ({req_func, req_data0, req_data1} !== {10'd3, 32'd5, 32'd7}) begin errors++; $display("FAIL single_req_fields: got %0d/%0d/%0d want 3/5/7", req_func, req_data0, req_data1); end
        tick;
        checks++; if ({req_valid, outstanding} !== {1'b0, 4'd1}) begin errors++; $display("FAIL single_issued: got valid=%0b out=%0d want 0/1", req_valid, outstanding); end
        resp_valid = 1; resp_status = 3'd0; resp_data = 32'd35;
        #1;
        checks++; if ({resp_ready, rsp_valid} !== 2'b11) begin errors++; $display("FAIL single_cut_through: got ready=%0b valid=%0b want 1/1", resp_ready, rsp_valid); end
        checks++; if ({rsp_status, rsp_data} !== {3'd0, 32'd35}) begin errors++; $display("FAIL single_rsp_data: got %0d/%0d want 0/35", rsp_status, rsp_data); end
        tick;
        resp_valid = 0;
        #1;
        checks++; if ({rsp_valid, outstanding} !== {1'b0, 4'd0}) begin errors++; $display("FAIL single_drained: got valid=%0b out=%0d want 0/0", rsp_valid, outstanding); end
    endtask

    task automatic test_stall;
        do_reset;
        req_ready = 0; rsp_ready = 1;
        cmd_valid = 1; cmd_state = 1; cmd_func = 10'h2A; cmd_data0 = 32'hA0A0; cmd_data1 = 32'hA1A1;
        tick;
        cmd_func = 10'h15; cmd_data0 = 32'hB0B0; cmd_data1 = 32'hB1B1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if ({req_valid, req_state, req_func, req_data0, req_data1} !== {1'b1, 1'b1, 10'h2A, 32'hA0A0, 32'hA1A1}) begin errors++; $display("FAIL stall_req_stable: cycle %0d got %0b/%0h/%0h/%0h", i, req_valid, req_func, req_data0, req_data1); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL stall_cmd_ready: cycle %0d got %0b want 0", i, cmd_ready); end
            tick;
        end
        cmd_valid = 0; req_ready = 1;
        tick;
        tick;
        checks++; if ({req_valid, outstanding} !== {1'b0, 4'd1}) begin errors++; $display("FAIL stall_one_handshake: got valid=%0b out=%0d want 0/1", req_valid, outstanding); end
    endtask

    task automatic test_max_outstanding;
        int acc = 0, issued = 0, rcount = 0;
        do_reset;
        req_ready = 1; rsp_ready = 1;
        for (int c = 0; c < 12; c++) begin
            cmd_valid = acc < 6; cmd_func = 10'(100 + acc); cmd_data0 = $urandom; cmd_data1 = $urandom;
            #1;
            if (req_valid && req_ready) begin
                checks++; if (req_func !== 10'(100 + issued)) begin errors++; $display("FAIL max_order: got %0d want %0d", req_func, 100 + issued); end
                issued++;
            end
            if (cmd_valid && cmd_ready) acc++;
            tick;
        end
        cmd_valid = acc < 6; cmd_func = 10'(100 + acc);
        #1;
        checks++; if (issued !== 4) begin errors++; $display("FAIL max_issued: got %0d want 4", issued); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL max_cmd_ready: got %0b want 0", cmd_ready); end
        checks++; if (outstanding !== 4'd4) begin errors++; $display("FAIL max_outstanding: got %0d want 4", outstanding); end
        for (int c = 0; c < 20; c++) begin
            cmd_valid = acc < 6; cmd_func = 10'(100 + acc);
            resp_valid = rcount < 4; resp_status = 3'd0; resp_data = $urandom;
            #1;
            if (req_valid && req_ready) begin
                checks++; if (req_func !== 10'(100 + issued)) begin errors++; $display("FAIL max_order: got %0d want %0d", req_func, 100 + issued); end
                issued++;
            end
            if (cmd_valid && cmd_ready) acc++;
            if (resp_valid && resp_ready) rcount++;
            tick;
        end
        cmd_valid = 0; resp_valid = 0;
        #1;
        checks++; if ({issued, rcount} !== {32'd6, 32'd4}) begin errors++; $display("FAIL max_drain: got issued=%0d resp=%0d want 6/4", issued, rcount); end
        checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL max_remaining: got %0d want 2", outstanding); end
    endtask

    task automatic test_skid;
        int n = 0, k = 0;
        logic [31:0] got [8];
        do_reset;
        issue(3);
        rsp_ready = 0;
        for (int c = 0; c < 6; c++) begin
            resp_valid = 1; resp_status = 3'd0; resp_data = 32'(n + 1);
            #1;
            if (resp_ready) n++;
            tick;
        end
        #1;
        checks++; if (n !== 2) begin errors++; $display("FAIL skid_buffered: got %0d want 2", n); end
        checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL skid_full_ready: got %0b want 0", resp_ready); end
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'd1}) begin errors++; $display("FAIL skid_head: got %0b/%0d want 1/1", rsp_valid, rsp_data); end
        rsp_ready = 1;
        for (int c = 0; c < 10; c++) begin
            resp_valid = n < 3; resp_data = 32'(n + 1);
            #1;
            if (rsp_valid && k < 8) begin got[k] = rsp_data; k++; end
            if (resp_valid && resp_ready) n++;
            tick;
        end
        resp_valid = 0;
        checks++; if (k !== 3) begin errors++; $display("FAIL skid_count: got %0d want 3", k); end
        for (int i = 0; i < 3 && i < k; i++) begin
            checks++; if (got[i] !== 32'(i + 1)) begin errors++; $display("FAIL skid_order: slot %0d got %0d want %0d", i, got[i], i + 1); end
        end
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL skid_outstanding: got %0d want 0", outstanding); end
    endtask

    task automatic test_errors;
        do_reset;
        issue(3);
        rsp_ready = 1;
        respond(3'd1, 32'd11);
        respond(3'd0, 32'd12);
        respond(3'd2, 32'd13);
        checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL err_count: got %0d want 2", err_count); end
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL err_outstanding: got %0d want 0", outstanding); end
        resp_valid = 1; resp_status = 3'd4; resp_data = 32'd99;
        #1;
        checks++; if ({resp_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL unsolicited_ready: got ready=%0b valid=%0b want 0/0", resp_ready, rsp_valid); end
        tick;
        tick;
        resp_valid = 0;
        checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL unsolicited_err: got %0d want 2", err_count); end
    endtask

    task automatic test_timeout;
        do_reset;
`ifdef CFU_L2_INITIATOR_TIMEOUT_EN
        cmd_valid = 1; cmd_func = 10'd1; req_ready = 1;
        tick;
        cmd_valid = 0;
        tick;
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL timeout_issue: got %0d want 1", outstanding); end
        for (int i = 1; i <= 7; i++) begin
            tick;
            checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: cycle %0d got %0b want 0", i, timeout); end
        end
        tick;
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_at_8: got %0b want 1", timeout); end
        for (int i = 0; i < 5; i++) tick;
        rsp_ready = 1;
        respond(3'd0, 32'd1);
        tick;
        checks++; if ({timeout, outstanding} !== {1'b1, 4'd0}) begin errors++; $display("FAIL timeout_sticky: got %0b/%0d want 1/0", timeout, outstanding); end
        do_reset;
        #1;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_reset: got %0b want 0", timeout); end
`else
        issue(1);
        for (int i = 0; i < 20; i++) tick;
        checks++; if ({timeout, outstanding} !== {1'b0, 4'd1}) begin errors++; $display("FAIL timeout_disabled: got %0b/%0d want 0/1", timeout, outstanding); end
`endif
    endtask

    task automatic test_reset_midflight;
        do_reset;
        issue(2);
        rsp_ready = 0;
        respond(3'd1, 32'd9);
        cmd_valid = 1; cmd_func = 10'd77; req_ready = 0;
        tick;
        checks++; if ({req_valid, rsp_valid, outstanding} !== {2'b11, 4'd1}) begin errors++; $display("FAIL midflight_setup: got %0b/%0b/%0d want 1/1/1", req_valid, rsp_valid, outstanding); end
        rst = 1; resp_valid = 1; resp_status = 3'd3; resp_data = 32'd5;
        tick;
        checks++; if ({req_valid, cmd_ready, resp_ready, rsp_valid} !== 4'b0000) begin errors++; $display("FAIL midflight_handshakes: got %b want 0000", {req_valid, cmd_ready, resp_ready, rsp_valid}); end
        checks++; if ({rsp_status, rsp_data, outstanding, err_count, timeout} !== 56'd0) begin errors++; $display("FAIL midflight_state: got st=%0d d=%0d out=%0d err=%0d to=%0b", rsp_status, rsp_data, outstanding, err_count, timeout); end
        rst = 0; cmd_valid = 0;
        #1;
        checks++; if ({resp_ready, rsp_valid} !== 2'b00) begin errors++; $display("FAIL post_reset_resp: got ready=%0b valid=%0b want 0/0", resp_ready, rsp_valid); end
        tick;
        resp_valid = 0;
        checks++; if ({err_count, outstanding} !== 20'd0) begin errors++; $display("FAIL post_reset_counts: got err=%0d out=%0d want 0/0", err_count, outstanding); end
    endtask

    task automatic test_random;
        cmd_t hq[$];
        rsp_t rq[$];
        int   m_out = 0, m_err = 0;
        logic e_cmd_ready, e_resp_ready, e_rsp_valid;
        rsp_t e_rsp;
        do_reset;
        for (int c = 0; c < 500; c++) begin
            cmd_valid = $urandom_range(0, 2) != 0; cmd_state = 1'($urandom); cmd_func = 10'($urandom);
            cmd_data0 = $urandom; cmd_data1 = $urandom;
            req_ready = $urandom_range(0, 3) != 0;
            resp_valid = $urandom_range(0, 1) != 0;
            resp_status = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            resp_data = $urandom;
            rsp_ready = $urandom_range(0, 2) != 0;
            #1;
            e_cmd_ready = (hq.size() == 0 || req_ready) && (m_out + hq.size() < MAXO);
            e_resp_ready = m_out > 0 && rq.size() < 2;
            e_rsp_valid = rq.size() > 0 || (resp_valid && e_resp_ready);
            e_rsp = rq.size() > 0 ? rq[0] : {resp_status, resp_data};
            checks++; if (cmd_ready !== e_cmd_ready) begin errors++; $display("FAIL rnd_cmd_ready: cycle %0d got %0b want %0b", c, cmd_ready, e_cmd_ready); end
            checks++; if (req_valid !== (hq.size() != 0)) begin errors++; $display("FAIL rnd_req_valid: cycle %0d got %0b want %0b", c, req_valid, hq.size() != 0); end
            if (hq.size() != 0) begin
                checks++; if ({req_state, req_func, req_data0, req_data1} !== hq[0]) begin errors++; $display("FAIL rnd_req_fields: cycle %0d got %0h want %0h", c, {req_state, req_func, req_data0, req_data1}, hq[0]); end
            end
            checks++; if (resp_ready !== e_resp_ready) begin errors++; $display("FAIL rnd_resp_ready: cycle %0d got %0b want %0b", c, resp_ready, e_resp_ready); end
            checks++; if (rsp_valid !== e_rsp_valid) begin errors++; $display("FAIL rnd_rsp_valid: cycle %0d got %0b want %0b", c, rsp_valid, e_rsp_valid); end
            if (e_rsp_valid) begin
                checks++; if ({rsp_status, rsp_data} !== e_rsp) begin errors++; $display("FAIL rnd_rsp: cycle %0d got %0d/%0h want %0d/%0h", c, rsp_status, rsp_data, e_rsp.s, e_rsp.d); end
            end
            checks++; if (outstanding !== 4'(m_out)) begin errors++; $display("FAIL rnd_outstanding: cycle %0d got %0d want %0d", c, outstanding, m_out); end
            checks++; if (err_count !== 16'(m_err)) begin errors++; $display("FAIL rnd_err_count: cycle %0d got %0d want %0d", c, err_count, m_err); end
            if (hq.size() != 0 && req_ready) begin
                void'(hq.pop_front());
                m_out++;
            end
            if (cmd_valid && e_cmd_ready) hq.push_back({cmd_state, cmd_func, cmd_data0, cmd_data1});
            if (resp_valid && e_resp_ready) begin
                m_out--;
                if (resp_status != 3'd0 && m_err < 65535) m_err++;
                rq.push_back({resp_status, resp_data});
            end
            if (e_rsp_valid && rsp_ready) void'(rq.pop_front());
            tick;
        end
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_state = 0; cmd_func = 0; cmd_data0 = 0; cmd_data1 = 0;
        req_ready = 0; resp_valid = 0; resp_status = 0; resp_data = 0; rsp_ready = 0;
        test_reset;
        test_single;
        test_stall;
        test_max_outstanding;
        test_skid;
        test_errors;
        test_timeout;
        test_reset_midflight;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
